// File: rtl/pic_pkg.sv
// Shared widths, flush opcode and quadrature phase encoding for the pic fetch front end.
package pic_pkg;

    localparam int PC_W        = 8;
    localparam int OP_W        = 14;
    localparam int STACK_DEPTH = 8;
    localparam logic [OP_W-1:0] NOP_OP = 14'h0000;

    typedef enum logic [1:0] {Q1 = 2'd0, Q2 = 2'd1, Q3 = 2'd2, Q4 = 2'd3} phase_t;

    function automatic logic [3:0] phase_strobe(input phase_t p);
        return 4'b0001 << p;
    endfunction

endpackage

// File: rtl/pic_stack.sv
// Circular hardware return stack: wraps silently on overflow/underflow and flags each with a one-clock pulse.
module pic_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] pop_data,
    output logic         ovf,
    output logic         unf
);

    localparam int SP_W  = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [SP_W-1:0]  sp;
    logic [SP_W-1:0]  sp_dec;
    logic [OCC_W-1:0] occ;

    assign sp_dec   = sp - SP_W'(1);
    assign pop_data = mem[sp_dec];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[sp] <= push_data;
        end
    end

    // Occupancy only tracks fullness for the pulses; sp keeps wrapping regardless.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp  <= '0;
            occ <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            ovf <= push && (occ == FULL);
            unf <= pop && !push && (occ == '0);
            if (push) begin
                sp <= sp + SP_W'(1);
                if (occ != FULL) occ <= occ + OCC_W'(1);
            end else if (pop) begin
                sp <= sp_dec;
                if (occ != '0) occ <= occ - OCC_W'(1);
            end
        end
    end

endmodule

// File: rtl/pic_fetch.sv
// pic instruction fetch: Q1..Q4 phase strobes, program counter, instruction register and return stack.
module pic_fetch
    import pic_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] prog_data,
    input  logic            jump_en,
    input  logic            call_en,
    input  logic            ret_en,
    input  logic            skip_en,
    input  logic [PC_W-1:0] jump_addr,
    output logic [PC_W-1:0] counter,
    output logic [OP_W-1:0] opcode,
    output logic            clk1,
    output logic            clk2,
    output logic            clk3,
    output logic            clk4,
    output logic            stack_ovf,
    output logic            stack_unf
);

    phase_t          phase;
    phase_t          phase_nxt;
    logic [3:0]      strobe;
    logic            update;
    logic            push;
    logic            pop;
    logic [PC_W-1:0] top;
    logic [PC_W-1:0] counter_nxt;
    logic [OP_W-1:0] opcode_nxt;

    assign phase_nxt = phase_t'(phase + 2'd1);
    assign {clk4, clk3, clk2, clk1} = strobe;
    assign update = strobe[3];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase  <= Q1;
            strobe <= 4'b0001;
        end else begin
            phase  <= phase_nxt;
            strobe <= phase_strobe(phase_nxt);
        end
    end

    // Return beats jump beats sequential; any redirect or skip discards the prefetched word.
    always_comb begin
        counter_nxt = counter + PC_W'(1);
        opcode_nxt  = prog_data;
        push        = 1'b0;
        pop         = 1'b0;
        if (ret_en) begin
            counter_nxt = top;
            pop         = update;
        end else if (jump_en) begin
            counter_nxt = jump_addr;
            push        = update && call_en;
        end
        if (ret_en || jump_en || skip_en) begin
            opcode_nxt = NOP_OP;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter <= '0;
            opcode  <= NOP_OP;
        end else if (update) begin
            counter <= counter_nxt;
            opcode  <= opcode_nxt;
        end
    end

    pic_stack #(
        .DEPTH(STACK_DEPTH),
        .W    (PC_W)
    ) u_stack (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .push_data(counter),
        .pop_data (top),
        .ovf      (stack_ovf),
        .unf      (stack_unf)
    );

endmodule

// File: doc/pic_fetch.md
Name: pic_fetch

Overview:
Instruction-fetch front end of the pic core. It generates the four quadrature phase strobes clk1..clk4, owns the program counter and an 8-level hardware return stack, and drives the program-memory address. It latches the 14-bit opcode into the instruction register for the decode/execute stage, which returns branch, call, return and skip requests.

Parameters:
PC_W, 8, program counter / program memory address width
OP_W, 14, opcode width
STACK_DEPTH, 8, return stack entries (power of two)
NOP_OP, 14'h0000, opcode injected on pipeline flush

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
prog_data  in  OP_W  program memory read data for address counter (combinational ROM)
jump_en  in  1  GOTO/CALL taken; load jump_addr
call_en  in  1  with jump_en: push return address
ret_en  in  1  RETURN/RETLW: pop stack into PC
skip_en  in  1  conditional skip taken (BTFSS/DECFSZ etc.)
jump_addr  in  PC_W  branch target
counter  out  PC_W  program counter = program memory address
opcode  out  OP_W  instruction register to decode
clk1, clk2, clk3, clk4  out  1  one-hot phase strobes Q1..Q4
stack_ovf  out  1  one-cycle pulse: push with stack full
stack_unf  out  1  one-cycle pulse: pop with stack empty

Behaviour:
- Reset (reset=0, async): phase=Q1 (clk1=1, others 0), counter=0, opcode=NOP_OP, sp=0, occupancy=0, stack_ovf=stack_unf=0; stack contents don't-care.
- Phase: 2-bit counter, Q1->Q2->Q3->Q4->Q1, one step per clk. clk1..clk4 is a registered one-hot decode, exactly one high at all times out of reset. One instruction cycle = 4 clk.
- Update edge: only the rising clk edge while clk4=1. counter, opcode and stack change there and nowhere else. jump_en/call_en/ret_en/skip_en/jump_addr are sampled only on that edge and ignored otherwise.
- Two-stage pipeline: during cycle n, decode executes opcode while prog_data shows the word at counter. At the update edge opcode <= prog_data, counter <= counter+1, unless a flush applies.
- Next-PC priority at update edge:
  - ret_en: counter <= top of stack, pop.
  - else jump_en: counter <= jump_addr; if call_en, push counter (already the return address).
  - else counter+1.
  - call_en without jump_en is ignored.
- Flush: if ret_en, jump_en or skip_en, opcode <= NOP_OP, discarding the prefetched word. Skip also gives counter+1 unless a higher-priority request is active. Every taken branch costs 2 instruction cycles.
- Arithmetic: counter+1 wraps modulo 2^PC_W (0xFF -> 0x00).
- Stack: circular, PIC style; sp is log2(STACK_DEPTH) bits.
  - Push writes stack[sp], then sp+1.
  - Pop does sp-1, then reads.
  - Occupancy counter saturates 0..STACK_DEPTH.
  - Push at full: ninth push overwrites the oldest entry and pulses stack_ovf for 1 clk.
  - Pop at empty: returns the wrapped entry and pulses stack_unf.
- Reset mid-cycle: immediate return to reset state. The first fetch after release occurs at the 4th rising edge (Q4).

Decomposition:
- Package pic_pkg: PC_W, OP_W, NOP_OP, and phase enum {Q1,Q2,Q3,Q4}.
- Sub-module pic_stack: circular LIFO with push/pop/data/ovf/unf, instantiated once.
- Phase generator, PC and IR stay in pic_fetch.

Test Plan:
- Reset, then ROM[0..3]=14'h3005,14'h0081,14'h0A81,14'h2800. Require:
  - clk1..clk4 rotate one-hot each clk.
  - At the first Q4 edge, opcode=14'h3005 and counter=1.
  - The next three instruction cycles give opcode 0081, 0A81, 2800 and counter 2, 3, 4.
- jump_en=1, jump_addr=8'h20 at a Q4 edge with counter=5 -> counter=0x20, opcode=NOP_OP. The next cycle gives opcode=ROM[0x20] and counter=0x21.
- CALL: jump_en=call_en=1, addr=0x40, counter=0x11. Later ret_en=1 -> counter=0x11, opcode=NOP, then ROM[0x11]. No ovf/unf pulse.
- skip_en=1 with counter=7 -> opcode=NOP_OP, counter=8. Skip together with jump_en -> the jump wins.
- 9 nested calls with return addresses 1..9 -> stack_ovf pulses on the 9th. Nine returns yield 9,8,7,6,5,4,3,2,9, and stack_unf pulses on the 9th pop.
- Drop reset during Q2 with counter=0x33 -> immediately counter=0, opcode=NOP_OP, clk1=1. counter=0xFF with no request -> counter wraps to 0x00.
